// File: rtl/reg_status_file_pkg.sv
// reg_status_file_pkg: shared widths, types and constants for the rename-tagged register file.
package reg_status_file_pkg;
    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int TAG_W = 5;
    localparam int IDX_W = $clog2(NREG);
    typedef logic [XLEN-1:0]  xlen_t;
    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [IDX_W-1:0] idx_t;
    localparam tag_t TAG_NONE = '0;
    localparam idx_t REG_X0   = '0;
endpackage

// File: rtl/reg_status_file_if.sv
// reg_status_file_if: dispatcher read/rename and ROB commit signals for reg_status_file.
interface reg_status_file_if;
    import reg_status_file_pkg::*;
    idx_t  disp_rs1_in;
    idx_t  disp_rs2_in;
    xlen_t disp_rs1_data_out;
    logic  disp_rs1_busy_out;
    tag_t  disp_rs1_tag_out;
    xlen_t disp_rs2_data_out;
    logic  disp_rs2_busy_out;
    tag_t  disp_rs2_tag_out;
    logic  disp_rename_en_in;
    idx_t  disp_rd_in;
    tag_t  disp_tag_in;
    logic  commit_en_in;
    idx_t  commit_rd_in;
    tag_t  commit_tag_in;
    xlen_t commit_value_in;

    modport master (
        output disp_rs1_in, disp_rs2_in, disp_rename_en_in, disp_rd_in, disp_tag_in,
               commit_en_in, commit_rd_in, commit_tag_in, commit_value_in,
        input  disp_rs1_data_out, disp_rs1_busy_out, disp_rs1_tag_out,
               disp_rs2_data_out, disp_rs2_busy_out, disp_rs2_tag_out
    );
    modport slave (
        input  disp_rs1_in, disp_rs2_in, disp_rename_en_in, disp_rd_in, disp_tag_in,
               commit_en_in, commit_rd_in, commit_tag_in, commit_value_in,
        output disp_rs1_data_out, disp_rs1_busy_out, disp_rs1_tag_out,
               disp_rs2_data_out, disp_rs2_busy_out, disp_rs2_tag_out
    );
endinterface

// File: rtl/reg_status_read_port.sv
// reg_status_read_port: combinational operand lookup for one source, with commit bypass.
module reg_status_read_port
    import reg_status_file_pkg::*;
(
    input  idx_t  rs_in,
    input  xlen_t value_in [NREG],
    input  tag_t  tag_in [NREG],
    input  logic  commit_en_in,
    input  idx_t  commit_rd_in,
    input  tag_t  commit_tag_in,
    input  xlen_t commit_value_in,
    output xlen_t data_out,
    output logic  busy_out,
    output tag_t  tag_out
);
    logic zero, bypass;
    always_comb begin
        zero     = (rs_in == REG_X0);
        bypass   = commit_en_in && (commit_rd_in == rs_in) && (tag_in[rs_in] == commit_tag_in);
        data_out = zero ? '0 : bypass ? commit_value_in : value_in[rs_in];
        tag_out  = (zero || bypass) ? TAG_NONE : tag_in[rs_in];
        busy_out = (tag_out != TAG_NONE);
    end
endmodule

// File: rtl/reg_status_file.sv
// reg_status_file: 32x32 architectural register file with per-register ROB rename tags.
// Optional retired-write counter enabled by defining REG_STATUS_PERF_CNT_EN.
module reg_status_file
    import reg_status_file_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              flush_in,
    reg_status_file_if.slave  bus,
    output logic [31:0]       perf_commit_cnt_out
);
    xlen_t value_q [NREG];
    xlen_t value_d [NREG];
    tag_t  tag_q [NREG];
    tag_t  tag_d [NREG];
    logic  commit_ok, rename_ok;

    always_comb begin
        commit_ok = rdy_in && bus.commit_en_in && (bus.commit_rd_in != REG_X0);
        rename_ok = rdy_in && bus.disp_rename_en_in && (bus.disp_rd_in != REG_X0) && !flush_in;
        value_d = value_q;
        tag_d   = tag_q;
        if (commit_ok) begin
            value_d[bus.commit_rd_in] = bus.commit_value_in;
            if (tag_q[bus.commit_rd_in] == bus.commit_tag_in)
                tag_d[bus.commit_rd_in] = TAG_NONE;
        end
        if (rdy_in && flush_in)
            tag_d = '{default: TAG_NONE};
        // Applied after commit so a same-register rename keeps its new tag.
        if (rename_ok)
            tag_d[bus.disp_rd_in] = bus.disp_tag_in;
        value_d[REG_X0] = '0;
        tag_d[REG_X0]   = TAG_NONE;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            value_q <= '{default: '0};
            tag_q   <= '{default: TAG_NONE};
        end else begin
            value_q <= value_d;
            tag_q   <= tag_d;
        end
    end

    reg_status_read_port u_rd1 (
        .rs_in(bus.disp_rs1_in), .value_in(value_q), .tag_in(tag_q),
        .commit_en_in(bus.commit_en_in), .commit_rd_in(bus.commit_rd_in),
        .commit_tag_in(bus.commit_tag_in), .commit_value_in(bus.commit_value_in),
        .data_out(bus.disp_rs1_data_out), .busy_out(bus.disp_rs1_busy_out),
        .tag_out(bus.disp_rs1_tag_out)
    );

    reg_status_read_port u_rd2 (
        .rs_in(bus.disp_rs2_in), .value_in(value_q), .tag_in(tag_q),
        .commit_en_in(bus.commit_en_in), .commit_rd_in(bus.commit_rd_in),
        .commit_tag_in(bus.commit_tag_in), .commit_value_in(bus.commit_value_in),
        .data_out(bus.disp_rs2_data_out), .busy_out(bus.disp_rs2_busy_out),
        .tag_out(bus.disp_rs2_tag_out)
    );

`ifdef REG_STATUS_PERF_CNT_EN
    logic [31:0] perf_cnt_q, perf_cnt_d;
    always_comb perf_cnt_d = commit_ok ? perf_cnt_q + 32'd1 : perf_cnt_q;
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) perf_cnt_q <= '0;
        else         perf_cnt_q <= perf_cnt_d;
    end
    assign perf_commit_cnt_out = perf_cnt_q;
`else
    assign perf_commit_cnt_out = '0;
`endif
endmodule

// File: tb/tb_reg_status_file.sv
// tb_reg_status_file: directed checks of read, rename, commit, flush, stall and x0 behaviour.
module tb_reg_status_file;
    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        flush_in = 1'b0;
    logic [31:0] perf_commit_cnt_out;
    int          n_run = 0;
    int          n_fail = 0;

    reg_status_file_if bus ();

    reg_status_file dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .bus(bus), .perf_commit_cnt_out(perf_commit_cnt_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        bus.disp_rename_en_in = 1'b0;
        bus.commit_en_in      = 1'b0;
        flush_in              = 1'b0;
        rdy_in                = 1'b1;
    endtask

    task automatic rename(input logic [4:0] rd, input logic [4:0] tg);
        bus.disp_rename_en_in = 1'b1;
        bus.disp_rd_in        = rd;
        bus.disp_tag_in       = tg;
    endtask

    task automatic commit(input logic [4:0] rd, input logic [4:0] tg, input logic [31:0] v);
        bus.commit_en_in    = 1'b1;
        bus.commit_rd_in    = rd;
        bus.commit_tag_in   = tg;
        bus.commit_value_in = v;
    endtask

    initial begin
        bus.disp_rs1_in = 5'd0;
        bus.disp_rs2_in = 5'd0;
        bus.disp_rd_in = 5'd0;
        bus.disp_tag_in = 5'd0;
        bus.commit_rd_in = 5'd0;
        bus.commit_tag_in = 5'd0;
        bus.commit_value_in = 32'd0;
        idle();
        #12 rst_in = 1'b1;
        tick();
        check("perf_after_reset", perf_commit_cnt_out, 32'd0);

        // Dirty x5, then assert reset away from any clock edge
        commit(5'd5, 5'd0, 32'hAA);
        rename(5'd5, 5'd3);
        tick();
        idle();
        bus.disp_rs1_in = 5'd5;
        #1;
        check("pre_reset_busy", {31'd0, bus.disp_rs1_busy_out}, 32'd1);
        #2 rst_in = 1'b0;
        #1;
        check("reset_data", bus.disp_rs1_data_out, 32'd0);
        check("reset_busy", {31'd0, bus.disp_rs1_busy_out}, 32'd0);
        check("reset_tag", {27'd0, bus.disp_rs1_tag_out}, 32'd0);
        rst_in = 1'b1;
        tick();

        // Rename then commit with same-cycle bypass
        rename(5'd5, 5'd3);
        tick();
        idle();
        #1;
        check("x5_busy", {31'd0, bus.disp_rs1_busy_out}, 32'd1);
        check("x5_tag", {27'd0, bus.disp_rs1_tag_out}, 32'd3);
        commit(5'd5, 5'd3, 32'hDEADBEEF);
        #1;
        check("x5_bypass_data", bus.disp_rs1_data_out, 32'hDEADBEEF);
        check("x5_bypass_busy", {31'd0, bus.disp_rs1_busy_out}, 32'd0);
        tick();
        idle();
        #1;
        check("x5_tag_cleared", {27'd0, bus.disp_rs1_tag_out}, 32'd0);
        check("x5_data", bus.disp_rs1_data_out, 32'hDEADBEEF);

        // Stale commit: value lands, newer tag survives
        rename(5'd7, 5'd4);
        tick();
        rename(5'd7, 5'd9);
        tick();
        idle();
        bus.disp_rs2_in = 5'd7;
        commit(5'd7, 5'd4, 32'h11);
        #1;
        check("x7_no_bypass_busy", {31'd0, bus.disp_rs2_busy_out}, 32'd1);
        check("x7_no_bypass_data", bus.disp_rs2_data_out, 32'd0);
        tick();
        idle();
        #1;
        check("x7_stale_data", bus.disp_rs2_data_out, 32'h11);
        check("x7_stale_busy", {31'd0, bus.disp_rs2_busy_out}, 32'd1);
        check("x7_stale_tag", {27'd0, bus.disp_rs2_tag_out}, 32'd9);

        // Commit + flush + rename in one cycle
        rename(5'd6, 5'd2);
        tick();
        commit(5'd6, 5'd2, 32'h42);
        rename(5'd8, 5'd5);
        flush_in = 1'b1;
        tick();
        idle();
        bus.disp_rs1_in = 5'd6;
        bus.disp_rs2_in = 5'd8;
        #1;
        check("x6_flush_data", bus.disp_rs1_data_out, 32'h42);
        check("x6_flush_busy", {31'd0, bus.disp_rs1_busy_out}, 32'd0);
        check("x8_rename_dropped", {31'd0, bus.disp_rs2_busy_out}, 32'd0);
        bus.disp_rs2_in = 5'd7;
        #1;
        check("x7_flushed_tag", {27'd0, bus.disp_rs2_tag_out}, 32'd0);
        check("x7_kept_data", bus.disp_rs2_data_out, 32'h11);

        // Rename and commit to same register: rename tag wins, value written
        rename(5'd9, 5'd6);
        commit(5'd9, 5'd0, 32'h77);
        tick();
        idle();
        bus.disp_rs1_in = 5'd9;
        #1;
        check("x9_tag_wins", {27'd0, bus.disp_rs1_tag_out}, 32'd6);
        check("x9_value", bus.disp_rs1_data_out, 32'h77);

        // x0 ignores rename and commit
        bus.disp_rs1_in = 5'd0;
        rename(5'd0, 5'd7);
        commit(5'd0, 5'd0, 32'h55);
        #1;
        check("x0_bypass_data", bus.disp_rs1_data_out, 32'd0);
        tick();
        idle();
        #1;
        check("x0_data", bus.disp_rs1_data_out, 32'd0);
        check("x0_busy", {31'd0, bus.disp_rs1_busy_out}, 32'd0);

        // Stall suppresses commit and flush
        rename(5'd10, 5'd8);
        tick();
        idle();
        rdy_in = 1'b0;
        commit(5'd3, 5'd0, 32'd7);
        flush_in = 1'b1;
        tick();
        idle();
        bus.disp_rs1_in = 5'd3;
        bus.disp_rs2_in = 5'd10;
        #1;
        check("x3_stalled", bus.disp_rs1_data_out, 32'd0);
        check("x10_stall_flush_tag", {27'd0, bus.disp_rs2_tag_out}, 32'd8);

        // Retired-write counter from a fresh reset
        #2 rst_in = 1'b0;
        #1 rst_in = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            commit((i == 4) ? 5'd0 : 5'(i + 1), 5'd0, 32'(i));
            tick();
        end
        idle();
        #1;
`ifdef REG_STATUS_PERF_CNT_EN
        check("perf_cnt", perf_commit_cnt_out, 32'd9);
`else
        check("perf_cnt_tied", perf_commit_cnt_out, 32'd0);
`endif
        bus.disp_rs1_in = 5'd10;
        #1;
        check("x10_after_loop", bus.disp_rs1_data_out, 32'd9);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
